// File: rtl/fb_write_scheduler_if.sv
// Write-side bundle of the frame buffer scheduler: clear control, two producer
// valid/ready channels and the memory write port.
interface fb_write_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned WORD_SIZE  = 18
);
    logic                  clear_start;
    logic [WORD_SIZE-1:0]  clear_color;
    logic                  clear_busy;
    logic                  clear_done;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [WORD_SIZE-1:0]  req0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [WORD_SIZE-1:0]  req1_data;

    logic                  wr_drop;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [WORD_SIZE-1:0]  mem_write_data;

    // Producers / clear requester side.
    modport master (
        output clear_start, clear_color,
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  clear_busy, clear_done, req0_ready, req1_ready,
        input  wr_drop, mem_write_en, mem_write_addr, mem_write_data
    );

    // Scheduler side.
    modport slave (
        input  clear_start, clear_color,
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output clear_busy, clear_done, req0_ready, req1_ready,
        output wr_drop, mem_write_en, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Frame buffer write scheduler: round-robin arbitration between two pixel
// producers, plus a full-buffer clear sequencer with absolute priority.
module fb_write_scheduler #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned WORD_SIZE  = 18,
    parameter int unsigned NUM_WORDS  = 49152
) (
    input logic                 clk,
    input logic                 rst_n,
    fb_write_scheduler_if.slave bus
);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    // One extra bit so NUM_WORDS == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   NumWordsExt = (ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LastAddr    = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]  color_q, color_d;
    logic                  last_grant_q, last_grant_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  drop_q, drop_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;

    logic                  grant_valid;
    logic                  grant_sel;
    logic                  run_open;
    logic                  ready0, ready1;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WORD_SIZE-1:0]  sel_data;
    logic                  sel_in_range;

    // Round-robin grant and combinational readies.
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = bus.req1_valid;
        end
        // The done-pulse cycle still belongs to the clear, so arbitration
        // resumes only on the cycle after it.
        run_open     = (state_q == StRun) && !done_q && !bus.clear_start;
        ready0       = run_open && grant_valid && !grant_sel;
        ready1       = run_open && grant_valid && grant_sel;
        xfer         = ready0 | ready1;
        sel_addr     = grant_sel ? bus.req1_addr : bus.req0_addr;
        sel_data     = grant_sel ? bus.req1_data : bus.req0_data;
        sel_in_range = {1'b0, sel_addr} < NumWordsExt;
    end

    // Next-state logic for the RUN / CLEAR / DONE sequencer and write port.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        color_d      = color_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        drop_d       = 1'b0;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        case (state_q)
            StRun: begin
                if (xfer) begin
                    last_grant_d = grant_sel;
                    if (sel_in_range) begin
                        wen_d   = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_data;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (bus.clear_start && !done_q) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    color_d = bus.clear_color;
                    busy_d  = 1'b1;
                end
            end
            StClear: begin
                wen_d   = 1'b1;
                waddr_d = cnt_q;
                wdata_d = color_q;
                if (cnt_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            color_q      <= '0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            color_q      <= color_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.req0_ready     = ready0;
    assign bus.req1_ready     = ready1;
    assign bus.clear_busy     = busy_q;
    assign bus.clear_done     = done_q;
    assign bus.wr_drop        = drop_q;
    assign bus.mem_write_en   = wen_q;
    assign bus.mem_write_addr = waddr_q;
    assign bus.mem_write_data = wdata_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: vector table for arbitration and
// range handling, hand-written sequences for full clear and reset mid-clear.
module tb_fb_write_scheduler;

    localparam int N = 49152;

    logic clk;
    logic rst_n;

    fb_write_scheduler_if #(.ADDR_WIDTH(16), .WORD_SIZE(18)) bus ();

    fb_write_scheduler #(
        .ADDR_WIDTH(16),
        .WORD_SIZE (18),
        .NUM_WORDS (N)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [15:0] a0;
        logic [17:0] d0;
        logic [15:0] a1;
        logic [17:0] d1;
        logic        r0;
        logic        r1;
        logic        en;
        logic        drop;
        logic [15:0] addr;
        logic [17:0] data;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic v0, input logic v1,
                           input logic [15:0] a0, input logic [17:0] d0,
                           input logic [15:0] a1, input logic [17:0] d1,
                           input logic r0, input logic r1, input logic en, input logic drop,
                           input logic [15:0] addr, input logic [17:0] data);
        vec_t v;
        v = '{v0, v1, a0, d0, a1, d1, r0, r1, en, drop, addr, data};
        vecs.push_back(v);
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, "_en"}, 32'(bus.mem_write_en), 32'(v.en));
        chk({tag, "_drop"}, 32'(bus.wr_drop), 32'(v.drop));
        if (v.en) begin
            chk({tag, "_addr"}, 32'(bus.mem_write_addr), 32'(v.addr));
            chk({tag, "_data"}, 32'(bus.mem_write_data), 32'(v.data));
        end
    endtask

    initial begin
        int   nwr, addr_err, data_err, en_err, busy_err, ready_err, overlap, ndone, done_k;
        bit   found;
        vec_t idle;

        // Round-robin with both valid, starting from reset (req0 wins first tie).
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) add_vec(1, 1, 16'h0010, 18'h3F000, 16'h0020, 18'h00FC0,
                                    1, 0, 1, 0, 16'h0010, 18'h3F000);
            else            add_vec(1, 1, 16'h0010, 18'h3F000, 16'h0020, 18'h00FC0,
                                    0, 1, 1, 0, 16'h0020, 18'h00FC0);
        end
        // req1 alone, four back-to-back accepts.
        for (int j = 0; j < 4; j++) begin
            add_vec(0, 1, 16'h0000, 18'h0, 16'(16'h0030 + j), 18'(18'h01000 + j),
                    0, 1, 1, 0, 16'(16'h0030 + j), 18'(18'h01000 + j));
        end
        // Pointer left at 1: next tie goes to req0, then req1.
        add_vec(1, 1, 16'h0040, 18'h00001, 16'h0050, 18'h00002, 1, 0, 1, 0, 16'h0040, 18'h00001);
        add_vec(1, 1, 16'h0040, 18'h00001, 16'h0050, 18'h00002, 0, 1, 1, 0, 16'h0050, 18'h00002);
        // Nobody valid.
        add_vec(0, 0, 16'h0000, 18'h0, 16'h0000, 18'h0, 0, 0, 0, 0, 16'h0, 18'h0);
        // First out-of-range address, last in-range address, top address.
        add_vec(1, 0, 16'hC000, 18'h3FFFF, 16'h0000, 18'h0, 1, 0, 0, 1, 16'h0, 18'h0);
        add_vec(0, 1, 16'h0000, 18'h0, 16'hBFFF, 18'h2AAAA, 0, 1, 1, 0, 16'hBFFF, 18'h2AAAA);
        add_vec(1, 0, 16'hFFFF, 18'h00001, 16'h0000, 18'h0, 1, 0, 0, 1, 16'h0, 18'h0);
        idle = '{0, 0, 16'h0, 18'h0, 16'h0, 18'h0, 0, 0, 0, 0, 16'h0, 18'h0};

        // Reset for two edges with both producers valid.
        rst_n           = 1'b0;
        bus.clear_start = 1'b0;
        bus.clear_color = '0;
        bus.req0_valid  = 1'b1;
        bus.req0_addr   = 16'h0010;
        bus.req0_data   = 18'h3F000;
        bus.req1_valid  = 1'b1;
        bus.req1_addr   = 16'h0020;
        bus.req1_data   = 18'h00FC0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven arbitration; registered outputs lag the vector by one cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            bus.req0_valid = vecs[i].v0;
            bus.req0_addr  = vecs[i].a0;
            bus.req0_data  = vecs[i].d0;
            bus.req1_valid = vecs[i].v1;
            bus.req1_addr  = vecs[i].a1;
            bus.req1_data  = vecs[i].d1;
            @(negedge clk);
            if (i == 0) begin
                chk("rst_en", 32'(bus.mem_write_en), 0);
                chk("rst_addr", 32'(bus.mem_write_addr), 0);
                chk("rst_data", 32'(bus.mem_write_data), 0);
                chk("rst_busy", 32'(bus.clear_busy), 0);
                chk("rst_done", 32'(bus.clear_done), 0);
                chk("rst_drop", 32'(bus.wr_drop), 0);
            end else begin
                chk_out($sformatf("vec%0d_out", i - 1), vecs[i-1]);
            end
            chk($sformatf("vec%0d_ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
            chk($sformatf("vec%0d_ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
            @(posedge clk);
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk_out("vec_last_out", vecs[vecs.size()-1]);
        chk("idle_ready0", 32'(bus.req0_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("idle_out", idle);

        // Full clear requested while req0 is valid (cycle t = k 0).
        @(posedge clk);
        #1;
        bus.req0_valid  = 1'b1;
        bus.req0_addr   = 16'h0100;
        bus.req0_data   = 18'h00001;
        bus.clear_start = 1'b1;
        bus.clear_color = 18'h00FC0;
        @(negedge clk);
        chk("clr_start_blocks_ready0", 32'(bus.req0_ready), 0);
        nwr = 0; addr_err = 0; data_err = 0; en_err = 0; busy_err = 0;
        ready_err = 0; overlap = 0; ndone = 0; done_k = -1;
        for (int k = 1; k <= N + 3; k++) begin
            @(posedge clk);
            #1;
            // A second start mid-clear, with a different colour, must be ignored.
            bus.clear_start = (k == 1000);
            bus.clear_color = 18'h3FFFF;
            @(negedge clk);
            if (bus.mem_write_en !== ((k >= 2) && (k <= N + 1))) en_err++;
            if (bus.mem_write_en === 1'b1) begin
                nwr++;
                if (bus.mem_write_addr !== 16'(k - 2)) addr_err++;
                if (bus.mem_write_data !== 18'h00FC0) data_err++;
                if (bus.wr_drop !== 1'b0) overlap++;
            end
            if (bus.clear_busy !== ((k >= 1) && (k <= N + 1))) busy_err++;
            if (bus.clear_done === 1'b1) begin
                ndone++;
                done_k = k;
            end
            if (k <= N + 2 && bus.req0_ready !== 1'b0) ready_err++;
            if (k == N + 3) chk("clr_accept_after", 32'(bus.req0_ready), 1);
        end
        chk("clr_writes", 32'(nwr), 32'(N));
        chk("clr_addr_err", 32'(addr_err), 0);
        chk("clr_data_err", 32'(data_err), 0);
        chk("clr_en_err", 32'(en_err), 0);
        chk("clr_busy_err", 32'(busy_err), 0);
        chk("clr_ready_err", 32'(ready_err), 0);
        chk("clr_drop_overlap", 32'(overlap), 0);
        chk("clr_done_count", 32'(ndone), 1);
        chk("clr_done_cycle", 32'(done_k), 32'(N + 2));
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("post_clr_en", 32'(bus.mem_write_en), 1);
        chk("post_clr_addr", 32'(bus.mem_write_addr), 32'h0100);
        chk("post_clr_data", 32'(bus.mem_write_data), 32'h00001);

        // Reset mid-clear at address 1000.
        @(posedge clk);
        #1;
        bus.clear_start = 1'b1;
        bus.clear_color = 18'h15555;
        @(posedge clk);
        #1;
        bus.clear_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (bus.mem_write_en === 1'b1 && bus.mem_write_addr === 16'd1000) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("mid_clr_reached_1000", 32'(found), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.clear_busy), 0);
        chk("mid_rst_en", 32'(bus.mem_write_en), 0);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_addr  = 16'h0200;
        bus.req1_addr  = 16'h0300;
        @(negedge clk);
        chk("mid_rst_run_ready0", 32'(bus.req0_ready), 1);
        chk("mid_rst_run_ready1", 32'(bus.req1_ready), 0);
        ndone = 0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (bus.clear_done === 1'b1) ndone++;
        end
        chk("mid_rst_no_done", 32'(ndone), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
